// File: rtl/blake2s_digest_collect.sv
// BLAKE2s digest collector: captures the byte-serial digest that follows the
// core's finished flag and packs it little-endian into a 256-bit word.
// It optionally compares the digest against an expected value and holds the
// result under a valid/ready handshake until the consumer takes it.
module blake2s_digest_collect #(
  parameter int NN_MAX = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [7:0]            nn_i,
  input  logic                  finished_i,
  input  logic [7:0]            h_i,
  input  logic                  cmp_en_i,
  input  logic [8*NN_MAX-1:0]   expected_i,
  input  logic                  digest_ready_i,
  output logic                  digest_v_o,
  output logic [8*NN_MAX-1:0]   digest_o,
  output logic [CNT_W-1:0]      digest_len_o,
  output logic                  match_o,
  output logic                  busy_o,
  output logic                  len_err_o,
  output logic                  overrun_o
);

  localparam logic [7:0]       NN_MAX_B = 8'(NN_MAX);
  localparam logic [CNT_W-1:0] NN_MAX_C = CNT_W'(NN_MAX);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

  state_t             state;
  logic               finished_q;
  logic [CNT_W-1:0]   cnt;
  logic               cmp_q;

  logic               start;
  logic               xfer;
  logic               accept;
  logic               drop;
  logic               len_bad;
  logic [CNT_W-1:0]   nn_eff;

  // Write path shared by the start cycle and the collect cycles
  logic               wr_en;
  logic [CNT_W-1:0]   wr_idx;
  logic [8*NN_MAX-1:0] wr_base;
  logic [CNT_W-1:0]   cap_len;
  logic               cap_cmp;
  logic [8*NN_MAX-1:0] digest_nxt;
  logic [8*NN_MAX-1:0] cmp_mask;
  logic               last;
  logic               match_nxt;

  // A held-high flag is one start; only the rising edge counts.
  assign start   = finished_i & ~finished_q;
  assign xfer    = (state == S_HOLD) & digest_ready_i;
  // A start is taken when idle, or when the held result leaves this same cycle.
  assign accept  = start & ((state == S_IDLE) | xfer);
  assign drop    = start & ~accept;
  assign len_bad = (nn_i == 8'd0) | (nn_i > NN_MAX_B);
  assign nn_eff  = len_bad ? NN_MAX_C : CNT_W'(nn_i);

  assign digest_v_o = (state == S_HOLD);
  assign busy_o     = (state != S_IDLE);

  // Next digest value and the compare against it, so match is ready on HOLD entry
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = cnt;
    wr_base  = digest_o;
    cap_len  = digest_len_o;
    cap_cmp  = cmp_q;
    cmp_mask = '0;
    if (accept) begin
      wr_en   = 1'b1;
      wr_idx  = '0;
      wr_base = '0;
      cap_len = nn_eff;
      cap_cmp = cmp_en_i;
    end else if (state == S_COLLECT) begin
      wr_en = 1'b1;
    end
    digest_nxt = wr_base;
    for (int k = 0; k < NN_MAX; k++) begin
      if (wr_en && (wr_idx == CNT_W'(k)))
        digest_nxt[8*k +: 8] = h_i;
      if (CNT_W'(k) < cap_len)
        cmp_mask[8*k +: 8] = 8'hFF;
    end
    last      = (wr_idx == (cap_len - ONE_C));
    match_nxt = cap_cmp & ~|((digest_nxt ^ expected_i) & cmp_mask);
  end

  // Capture FSM with registered result outputs and status pulses
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= S_IDLE;
      finished_q   <= 1'b0;
      cnt          <= '0;
      cmp_q        <= 1'b0;
      digest_o     <= '0;
      digest_len_o <= '0;
      match_o      <= 1'b0;
      len_err_o    <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      finished_q <= finished_i;
      len_err_o  <= start & len_bad;
      overrun_o  <= drop;
      if (wr_en)
        digest_o <= digest_nxt;
      if (accept) begin
        digest_len_o <= nn_eff;
        cmp_q        <= cmp_en_i;
        cnt          <= ONE_C;
        match_o      <= last ? match_nxt : 1'b0;
        state        <= last ? S_HOLD : S_COLLECT;
      end else begin
        case (state)
          S_COLLECT: begin
            cnt <= cnt + ONE_C;
            if (last) begin
              match_o <= match_nxt;
              state   <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (xfer)
              state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blake2s_digest_collect.sv
// Directed bench for blake2s_digest_collect: capture lengths, compare,
// length error, back-pressure/overrun and asynchronous reset abort.
module tb_blake2s_digest_collect;

  logic         clk = 1'b0;
  logic         nreset;
  logic [7:0]   nn_i;
  logic         finished_i;
  logic [7:0]   h_i;
  logic         cmp_en_i;
  logic [255:0] expected_i;
  logic         digest_ready_i;
  logic         digest_v_o;
  logic [255:0] digest_o;
  logic [5:0]   digest_len_o;
  logic         match_o;
  logic         busy_o;
  logic         len_err_o;
  logic         overrun_o;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [255:0] PAT =
    256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;

  blake2s_digest_collect dut (
    .clk(clk), .nreset(nreset), .nn_i(nn_i), .finished_i(finished_i),
    .h_i(h_i), .cmp_en_i(cmp_en_i), .expected_i(expected_i),
    .digest_ready_i(digest_ready_i), .digest_v_o(digest_v_o),
    .digest_o(digest_o), .digest_len_o(digest_len_o), .match_o(match_o),
    .busy_o(busy_o), .len_err_o(len_err_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a capture and feed n bytes of data; reports whether valid rose early
  // and what len_err showed right after the start edge.
  task automatic capture(input logic [7:0] nn, input logic cmp, input logic [255:0] data,
                         input int n, output logic early, output logic lerr);
    nn_i       = nn;
    cmp_en_i   = cmp;
    finished_i = 1'b1;
    h_i        = data[7:0];
    tick();
    finished_i = 1'b0;
    lerr       = len_err_o;
    early      = 1'b0;
    for (int k = 1; k < n; k++) begin
      early = early | digest_v_o;
      h_i   = data[8*k +: 8];
      tick();
    end
    h_i = 8'h00;
  endtask

  task automatic handshake();
    digest_ready_i = 1'b1;
    tick();
    digest_ready_i = 1'b0;
  endtask

  initial begin
    logic         early, lerr;
    logic [255:0] exp_v;

    nreset = 1'b0; nn_i = 8'd0; finished_i = 1'b0; h_i = 8'h00;
    cmp_en_i = 1'b0; expected_i = '0; digest_ready_i = 1'b0;
    tick(); tick();
    chk("rst_valid",   digest_v_o,   0);
    chk("rst_digest",  digest_o,     0);
    chk("rst_len",     digest_len_o, 0);
    chk("rst_match",   match_o,      0);
    chk("rst_busy",    busy_o,       0);
    chk("rst_lenerr",  len_err_o,    0);
    chk("rst_overrun", overrun_o,    0);
    nreset = 1'b1;
    tick();

    // nn=32 straight capture
    capture(8'd32, 1'b0, PAT, 32, early, lerr);
    chk("n32_early",  early,        0);
    chk("n32_lenerr", lerr,         0);
    chk("n32_valid",  digest_v_o,   1);
    chk("n32_digest", digest_o,     PAT);
    chk("n32_len",    digest_len_o, 32);
    chk("n32_match",  match_o,      0);
    chk("n32_busy",   busy_o,       1);
    tick(); tick();
    chk("n32_hold",   digest_o,     PAT);
    handshake();
    chk("n32_done_v", digest_v_o,   0);
    chk("n32_done_b", busy_o,       0);

    // nn=1 with ready held high: one-cycle valid
    digest_ready_i = 1'b1;
    capture(8'd1, 1'b0, {248'h0, 8'ha5}, 1, early, lerr);
    chk("n1_valid",  digest_v_o,   1);
    chk("n1_digest", digest_o,     256'ha5);
    chk("n1_len",    digest_len_o, 1);
    tick();
    chk("n1_vlow",   digest_v_o,   0);
    digest_ready_i = 1'b0;

    // compare: equal, top bit flipped, nn=16 with garbage upper bytes
    expected_i = PAT;
    capture(8'd32, 1'b1, PAT, 32, early, lerr);
    chk("cmp_eq", match_o, 1);
    handshake();
    exp_v = PAT; exp_v[255] = ~exp_v[255];
    expected_i = exp_v;
    capture(8'd32, 1'b1, PAT, 32, early, lerr);
    chk("cmp_b255", match_o, 0);
    handshake();
    exp_v = {128'hdeadbeef_cafef00d_12345678_9abcdef0, PAT[127:0]};
    expected_i = exp_v;
    capture(8'd16, 1'b1, PAT, 16, early, lerr);
    chk("cmp16_early",  early,        0);
    chk("cmp16_match",  match_o,      1);
    chk("cmp16_digest", digest_o,     {128'h0, PAT[127:0]});
    chk("cmp16_len",    digest_len_o, 16);
    handshake();
    exp_v[0] = ~exp_v[0];
    expected_i = exp_v;
    capture(8'd16, 1'b1, PAT, 16, early, lerr);
    chk("cmp16_b0", match_o, 0);
    handshake();

    // nn=0 behaves as 32 and flags a length error
    capture(8'd0, 1'b0, PAT, 32, early, lerr);
    chk("nn0_lenerr", lerr,         1);
    chk("nn0_early",  early,        0);
    chk("nn0_pulse",  len_err_o,    0);
    chk("nn0_len",    digest_len_o, 32);
    chk("nn0_digest", digest_o,     PAT);
    handshake();

    // back-pressure: dropped start in HOLD, then start together with ready
    capture(8'd4, 1'b0, {224'h0, 32'hdeadbeef}, 4, early, lerr);
    chk("bp_digest", digest_o, 256'hdeadbeef);
    tick(); tick(); tick();
    finished_i = 1'b1; nn_i = 8'd4; h_i = 8'h55;
    tick();
    finished_i = 1'b0;
    chk("bp_overrun", overrun_o, 1);
    chk("bp_keep",    digest_o,  256'hdeadbeef);
    chk("bp_valid",   digest_v_o, 1);
    tick();
    chk("bp_ovr_low", overrun_o, 0);
    tick(); tick(); tick(); tick(); tick();
    chk("bp_keep2",   digest_o,  256'hdeadbeef);
    finished_i = 1'b1; digest_ready_i = 1'b1; nn_i = 8'd2; h_i = 8'h77;
    tick();
    finished_i = 1'b0; digest_ready_i = 1'b0;
    chk("bp3_ovr",    overrun_o,  0);
    chk("bp3_byte0",  digest_o,   256'h77);
    chk("bp3_valid",  digest_v_o, 0);
    chk("bp3_busy",   busy_o,     1);
    h_i = 8'h88;
    tick();
    chk("bp3_done",   digest_v_o, 1);
    chk("bp3_digest", digest_o,   256'h8877);
    chk("bp3_len",    digest_len_o, 2);
    handshake();

    // start during COLLECT is dropped; then reset aborts at byte 7
    nn_i = 8'd32; cmp_en_i = 1'b0; finished_i = 1'b1; h_i = PAT[7:0];
    tick();
    for (int k = 1; k < 8; k++) begin
      h_i = PAT[8*k +: 8];
      finished_i = (k == 4);
      tick();
      if (k == 4) chk("col_overrun", overrun_o, 1);
    end
    finished_i = 1'b0;
    chk("col_partial", digest_o, {192'h0, PAT[63:0]});
    nreset = 1'b0;
    #1;
    chk("abort_digest", digest_o,     0);
    chk("abort_valid",  digest_v_o,   0);
    chk("abort_busy",   busy_o,       0);
    chk("abort_len",    digest_len_o, 0);
    tick();
    nreset = 1'b1;
    tick();
    capture(8'd32, 1'b0, ~PAT, 32, early, lerr);
    chk("post_early",  early,        0);
    chk("post_digest", digest_o,     ~PAT);
    chk("post_len",    digest_len_o, 32);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
